// File: rtl/alu_issue_decoder.sv
// ALU issue decoder: decodes an RV64I instruction into a 4-bit ALU op and operands,
// registered in a single valid/ready stage feeding the ALU.
// Optional feature macro: ALU_ISSUE_NOR_EN (custom-0 NOR encoding).
module alu_issue_decoder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
`ifdef ALU_ISSUE_NOR_EN
    localparam logic [3:0] OpNor = 4'b1100;
`endif

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [3:0]       dec_op;
    logic [WIDTH-1:0] dec_b;
    logic             dec_illegal;
    logic             accept;
    logic             unused_rs1_field;

    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             ill_q;
    logic [CNT_W-1:0] cnt_q;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    // rs1 index field is not needed: operand A always comes from rs1_data
    assign unused_rs1_field = ^instr[19:15];

    // Decode op code, operand B and legality; illegal entries fall back to ADD rs1, rs2
    always_comb begin
        dec_op      = OpAdd;
        dec_b       = rs2_data;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (f3 == 3'b000 && f7 == 7'b0000000)      dec_op = OpAdd;
                else if (f3 == 3'b000 && f7 == 7'b0100000) dec_op = OpSub;
                else if (f3 == 3'b111 && f7 == 7'b0000000) dec_op = OpAnd;
                else if (f3 == 3'b110 && f7 == 7'b0000000) dec_op = OpOr;
                else                                       dec_illegal = 1'b1;
            end
            7'b0010011: begin
                case (f3)
                    3'b000: begin dec_op = OpAdd; dec_b = imm_i; end
                    3'b111: begin dec_op = OpAnd; dec_b = imm_i; end
                    3'b110: begin dec_op = OpOr;  dec_b = imm_i; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b0000011: dec_b = imm_i;
            7'b0100011: dec_b = imm_s;
            7'b1100011: begin
                if (f3 == 3'b000 || f3 == 3'b001) dec_op = OpSub;
                else                              dec_illegal = 1'b1;
            end
`ifdef ALU_ISSUE_NOR_EN
            7'b0001011: begin
                if (f3 == 3'b000 && f7 == 7'b0000000) dec_op = OpNor;
                else                                  dec_illegal = 1'b1;
            end
`endif
            default: dec_illegal = 1'b1;
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage register: flush wins over accept; data holds unless a new entry lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OpAdd;
            ill_q   <= 1'b0;
        end else begin
            if (flush)          valid_q <= 1'b0;
            else if (accept)    valid_q <= 1'b1;
            else if (out_ready) valid_q <= 1'b0;
            if (accept && !flush) begin
                a_q   <= rs1_data;
                b_q   <= dec_b;
                op_q  <= dec_op;
                ill_q <= dec_illegal;
            end
        end
    end

    // Saturating count of illegal instructions that actually entered the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && !flush && dec_illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid   = valid_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign illegal     = ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: driver pushes hand-computed expectations,
// a monitor pops and compares on every output transfer.
module tb_alu_issue_decoder;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] rs1_data = '0;
    logic [63:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, illegal;
    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  illegal_cnt;

    logic        in_ready2, out_valid2, illegal2;
    logic [63:0] alu_a2, alu_b2;
    logic [3:0]  alu_op2;
    logic [1:0]  illegal_cnt2;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    alu_issue_decoder #(.WIDTH(64), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    // Narrow-counter copy on the same stimulus, used for the saturation check
    alu_issue_decoder #(.WIDTH(64), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_op(alu_op2), .illegal(illegal2), .illegal_cnt(illegal_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [63:0] a,
                                input logic [63:0] b, input logic ill);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.ill = ill;
        return e;
    endfunction

    // Present one instruction, wait (bounded) for in_ready, record its expectation
    task automatic send(input logic [31:0] i, input logic [63:0] r1, input logic [63:0] r2,
                        input exp_t e);
        int n = 0;
        instr = i; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for instr %h", i);
        end else begin
            exp_q.push_back(e);
            if (e.ill) exp_cnt++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: compare every registered entry the ALU side takes
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got op %h a %h b %h expected no entry",
                             alu_op, alu_a, alu_b);
                end else begin
                    e = exp_q.pop_front();
                    chk("alu_op", {60'd0, alu_op}, {60'd0, e.op});
                    chk("alu_a", alu_a, e.a);
                    chk("alu_b", alu_b, e.b);
                    chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_alu_op", {60'd0, alu_op}, 64'h2);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        chk("rst_cnt", {56'd0, illegal_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Legal decodes
        send(32'h002081B3, 64'd5, 64'd7, mk(4'h2, 64'd5, 64'd7, 1'b0));          // ADD
        send(32'h402081B3, 64'd5, 64'd7, mk(4'h6, 64'd5, 64'd7, 1'b0));          // SUB
        send(32'hFFF00093, 64'd0, 64'h123, mk(4'h2, 64'd0, '1, 1'b0));           // ADDI -1
        send(32'h0020A423, 64'h1000, 64'h55, mk(4'h2, 64'h1000, 64'd8, 1'b0));   // SW 8
        send(32'hFE20AE23, 64'h2000, 64'h55,
             mk(4'h2, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0));                 // SW -4
        send(32'h0020F1B3, 64'hF0F0, 64'h0FF0, mk(4'h0, 64'hF0F0, 64'h0FF0, 1'b0)); // AND
        send(32'h0020E1B3, 64'hF0F0, 64'h0FF0, mk(4'h1, 64'hF0F0, 64'h0FF0, 1'b0)); // OR
        send(32'hFF017093, 64'h77, 64'h1,
             mk(4'h0, 64'h77, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0));                   // ANDI -16
        send(32'hFF80B283, 64'h300, 64'h1,
             mk(4'h2, 64'h300, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0));                  // LD -8
        send(32'h00209063, 64'd9, 64'd4, mk(4'h6, 64'd9, 64'd4, 1'b0));          // BNE

        // Backpressure: X sits in the stage while Y waits
        send(32'h002081B3, 64'h11, 64'h22, mk(4'h2, 64'h11, 64'h22, 1'b0));
        out_ready = 1'b0;
        instr = 32'h402081B3; rs1_data = 64'h33; rs2_data = 64'h44; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_alu_op", {60'd0, alu_op}, 64'h2);
            chk("bp_alu_a", alu_a, 64'h11);
            chk("bp_alu_b", alu_b, 64'h22);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        exp_q.push_back(mk(4'h6, 64'h33, 64'h44, 1'b0));
        @(negedge clk);
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // Flush with a simultaneous accept drops the entry and its count
        repeat (2) @(posedge clk);
        #1;
        instr = 32'h0; rs1_data = 64'h1; rs2_data = 64'h2; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_cnt", {56'd0, illegal_cnt}, 64'd0);
        @(posedge clk);
        #1;

        // Three all-zero illegals
        for (int k = 0; k < 3; k++) begin
            send(32'h0, 64'(k + 10), 64'(k + 20), mk(4'h2, 64'(k + 10), 64'(k + 20), 1'b1));
        end
        @(negedge clk);
        chk("cnt_after_3", {56'd0, illegal_cnt}, 64'd3);
        chk("cnt2_after_3", {62'd0, illegal_cnt2}, 64'd3);
        @(posedge clk);
        #1;

        // More illegals, plus the custom-0 NOR encoding
        send(32'h0020C063, 64'h5, 64'h6, mk(4'h2, 64'h5, 64'h6, 1'b1));          // BLT
        send(32'h002091B3, 64'h7, 64'h8, mk(4'h2, 64'h7, 64'h8, 1'b1));          // SLL
`ifdef ALU_ISSUE_NOR_EN
        send(32'h0000000B, 64'hA, 64'hB, mk(4'hC, 64'hA, 64'hB, 1'b0));
`else
        send(32'h0000000B, 64'hA, 64'hB, mk(4'h2, 64'hA, 64'hB, 1'b1));
`endif
        repeat (2) @(negedge clk);
        chk("cnt_final", {56'd0, illegal_cnt}, 64'(exp_cnt));
        chk("cnt2_saturated", {62'd0, illegal_cnt2}, 64'd3);

        // Every expected entry must have been observed
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while an entry is held
        @(posedge clk);
        #1 out_ready = 1'b0;
        instr = 32'h002081B3; rs1_data = 64'h99; rs2_data = 64'h98; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_cnt", {56'd0, illegal_cnt}, 64'd0);
        chk("async_rst_alu_a", alu_a, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
- Producer end of the 4-bit ALU op interface.
- Accepts a 32-bit RV64I instruction plus register-file operands, decodes the ALU operation code, selects operand B (rs2 or sign-extended immediate), and registers the result in an ID/EX-style stage feeding the ALU.
- Valid/ready handshake on both sides, synchronous flush, and a saturating illegal-instruction counter.

Parameters:
- WIDTH, 64, datapath width of operands; must be ≥ 32.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction/operands valid.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  RV64I instruction word.
- rs1_data  input  WIDTH  register operand 1.
- rs2_data  input  WIDTH  register operand 2.
- flush  input  1  kill the registered entry (branch redirect).
- out_valid  output  1  registered entry valid.
- out_ready  input  1  ALU stage accepts.
- alu_a  output  WIDTH  operand A to the ALU.
- alu_b  output  WIDTH  operand B to the ALU.
- alu_op  output  4  ALU op code.
- illegal  output  1  registered entry is an unsupported instruction.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Op encoding: AND=0000, OR=0001, ADD=0010, SUB=0110, NOR=1100.
- Reset (async, rst_n=0): out_valid=0, alu_a=0, alu_b=0, alu_op=0010, illegal=0, illegal_cnt=0.
- in_ready = !out_valid || out_ready. This is combinational with no skid buffer; throughput is 1 per cycle.
- Accept: the transfer occurs when in_valid && in_ready.
  - On accept, all outputs load the decoded values next edge and out_valid=1.
  - Latency is 1 cycle from accept to out_valid.
- Hold: if out_valid && !out_ready, all outputs hold stable.
- Drain: if out_ready && !(accept), out_valid→0 and data outputs hold their last values.
- Flush: synchronous; forces out_valid→0 next edge and dominates a simultaneous accept (entry dropped, illegal_cnt not incremented for it). in_ready is unaffected by flush.
- Decode, keyed on opcode = instr[6:0]:
  - 0110011 R-type, alu_a=rs1, alu_b=rs2:
    - f3=000, f7=0000000 → ADD.
    - f3=000, f7=0100000 → SUB.
    - f3=111, f7=0 → AND.
    - f3=110, f7=0 → OR.
  - 0010011 I-type, alu_b=sext(instr[31:20]):
    - f3=000 → ADD.
    - f3=111 → AND.
    - f3=110 → OR.
  - 0000011 load, any f3 → ADD, alu_b=sext(instr[31:20]).
  - 0100011 store → ADD, alu_b=sext({instr[31:25],instr[11:7]}).
  - 1100011 branch, f3=000/001 (BEQ/BNE) → SUB, alu_b=rs2.
  - Any other combination → illegal=1, alu_op=0010, alu_a=rs1, alu_b=rs2.
- Sign extension replicates instr[31] to WIDTH bits.
- illegal_cnt: increments on each accepted (not flushed) illegal instruction and saturates at all-ones. It is not cleared by flush, only by reset.
- Reset mid-transfer: the entry is lost and out_valid drops immediately (async).

Optional Feature:
- Macro: ALU_ISSUE_NOR_EN.
- Defined: opcode 0001011 (custom-0), f3=000, f7=0 decodes to NOR (1100), alu_a=rs1, alu_b=rs2, illegal=0.
- Undefined: that encoding is illegal like any other unsupported instruction.

Test Plan:
- Reset, then ADD x3,x1,x2: instr=0x002081B3, rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, alu_op=0010, alu_a=5, alu_b=7, illegal=0.
- SUB: instr=0x402081B3 → alu_op=0110. ADDI x1,x0,-1: instr=0xFFF00093 → alu_op=0010, alu_b=0xFFFF_FFFF_FFFF_FFFF.
- SW x2,8(x1): instr=0x0020A423, rs1=0x1000 → alu_op=0010, alu_a=0x1000, alu_b=8.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable; raise out_ready → next instruction loads the same cycle, no drop or duplicate.
- Flush with simultaneous accept → out_valid=0 next cycle. Accept instr=0x00000000 three times → illegal=1 each time, illegal_cnt=3. With CNT_W=2, 5 illegals → illegal_cnt=3 (saturated).
- instr=0x0000000B: with ALU_ISSUE_NOR_EN defined → alu_op=1100, illegal=0; without the macro → illegal=1, alu_op=0010.
